// File: rtl/cacheline_adaptor_p_if.sv
// Bundles the cache-side and memory-side buses of the cacheline adaptor.
// The adaptor connects through slave; its environment connects through master.
interface cacheline_adaptor_p_if #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
);
  localparam int unsigned aw = 32;

  // cache datapath / control side
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [aw-1:0]      address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;

  // memory side
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [aw-1:0]      address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor_p.sv
// Converts single-cycle cacheline fill/writeback requests into fixed-length
// memory bursts of s_line/s_burst beats, sharing one line buffer for both.
module cacheline_adaptor_p #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
) (
  input  logic clk,
  input  logic rst,
  cacheline_adaptor_p_if.slave bus
);
  localparam int unsigned aw    = 32;
  localparam int unsigned beats = s_line / s_burst;
  localparam int unsigned cw    = (beats > 1) ? $clog2(beats) : 1;
  localparam int unsigned off_w = $clog2(s_line / 8);
  localparam logic [cw-1:0] last_beat = cw'(beats - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [cw-1:0]     cnt_q, cnt_d;
  logic [s_line-1:0] buf_q, buf_d;
  logic [aw-1:0]     addr_q, addr_d;

  // State, beat counter, line buffer and latched address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state: read wins over write in IDLE; beats advance only on resp_i
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.read_i) begin
          addr_d  = bus.address_i;
          cnt_d   = '0;
          state_d = RD_BURST;
        end else if (bus.write_i) begin
          addr_d  = bus.address_i;
          buf_d   = bus.line_i;
          cnt_d   = '0;
          state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        if (bus.resp_i) begin
          buf_d[int'(cnt_q) * s_burst +: s_burst] = bus.burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_beat) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      WR_BURST: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_beat) begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state, counter and buffer
  always_comb begin
    bus.burst_o = '0;
    if (state_q == WR_BURST) begin
      bus.burst_o = buf_q[int'(cnt_q) * s_burst +: s_burst];
    end
  end

  assign bus.read_o    = (state_q == RD_BURST);
  assign bus.write_o   = (state_q == WR_BURST);
  assign bus.resp_o    = (state_q == DONE);
  assign bus.line_o    = buf_q;
  assign bus.address_o = {addr_q[aw-1:off_w], off_w'(0)};

endmodule

// File: tb/tb_cacheline_adaptor_p.sv
// Directed bench for cacheline_adaptor_p: fills, writeback, stalls, reset abort.
module tb_cacheline_adaptor_p;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cacheline_adaptor_p_if #(.s_line(256), .s_burst(64)) bus ();

  cacheline_adaptor_p #(.s_line(256), .s_burst(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Fill one line; pat gives resp_i per cycle (1 once exhausted); both also raises write_i
  task automatic do_fill(input logic [31:0] addr, input logic [63:0] bt [4],
                         input logic [15:0] pat, input int plen, input logic both);
    int n;
    int k;
    logic r;
    logic [255:0] exp_line;
    exp_line = {bt[3], bt[2], bt[1], bt[0]};
    @(negedge clk);
    bus.address_i = addr;
    bus.read_i    = 1'b1;
    bus.write_i   = both;
    bus.resp_i    = 1'b0;
    @(negedge clk);
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = ~addr;
    check("fill_read_o_start", 256'(bus.read_o), 256'(1));
    check("fill_address_o", 256'(bus.address_o), 256'({addr[31:5], 5'b0}));
    n = 0;
    k = 0;
    while (n < 4 && k < 40) begin
      r = (k < plen) ? pat[k] : 1'b1;
      bus.resp_i  = r;
      bus.burst_i = r ? bt[n] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (r) n++;
      k++;
      @(negedge clk);
      check("fill_read_o", 256'(bus.read_o), 256'(n < 4));
      check("fill_write_o", 256'(bus.write_o), 256'(0));
      check("fill_resp_o", 256'(bus.resp_o), 256'(n == 4));
    end
    check("fill_beats", 256'(n), 256'(4));
    bus.resp_i = 1'b0;
    check("fill_line_o", bus.line_o, exp_line);
    @(negedge clk);
    check("fill_resp_o_after", 256'(bus.resp_o), 256'(0));
    check("fill_line_o_held", bus.line_o, exp_line);
  endtask

  // Write back a line; abort_at in 0..3 pulses reset during that beat
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int abort_at);
    @(negedge clk);
    bus.address_i = addr;
    bus.line_i    = line;
    bus.write_i   = 1'b1;
    bus.resp_i    = 1'b0;
    @(negedge clk);
    bus.write_i   = 1'b0;
    bus.line_i    = ~line;
    bus.address_i = ~addr;
    check("wr_address_o", 256'(bus.address_o), 256'({addr[31:5], 5'b0}));
    for (int b = 0; b < 4; b++) begin
      check("wr_write_o", 256'(bus.write_o), 256'(1));
      check("wr_read_o", 256'(bus.read_o), 256'(0));
      check("wr_burst_o", 256'(bus.burst_o), 256'(line[b*64 +: 64]));
      if (b == abort_at) begin
        #2 rst = 1'b0;
        #1;
        check("abort_write_o", 256'(bus.write_o), 256'(0));
        check("abort_burst_o", 256'(bus.burst_o), 256'(0));
        check("abort_address_o", 256'(bus.address_o), 256'(0));
        check("abort_line_o", bus.line_o, 256'(0));
        bus.resp_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.resp_i = 1'b0;
        rst = 1'b1;
        check("abort_resp_o", 256'(bus.resp_o), 256'(0));
        @(negedge clk);
        check("abort_idle_resp_o", 256'(bus.resp_o), 256'(0));
        check("abort_idle_write_o", 256'(bus.write_o), 256'(0));
        return;
      end
      bus.resp_i = 1'b1;
      @(negedge clk);
    end
    bus.resp_i = 1'b0;
    check("wr_resp_o", 256'(bus.resp_o), 256'(1));
    check("wr_write_o_done", 256'(bus.write_o), 256'(0));
    check("wr_burst_o_done", 256'(bus.burst_o), 256'(0));
    check("wr_line_o", bus.line_o, line);
    @(negedge clk);
    check("wr_resp_o_after", 256'(bus.resp_o), 256'(0));
  endtask

  logic [63:0]  b1 [4];
  logic [63:0]  b2 [4];
  logic [63:0]  b3 [4];
  logic [255:0] wline;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.line_i = '0;
    bus.address_i = '0;
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    bus.burst_i = '0;
    bus.resp_i = 1'b0;
    b1 = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
           64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    b2 = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
           64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};
    b3 = '{64'h0F0F_0F0F_0000_0010, 64'hF0F0_F0F0_0000_0020,
           64'h5A5A_5A5A_0000_0030, 64'hA5A5_A5A5_0000_0040};
    wline = 256'h0123456789ABCDEF_1032547698BADCFE_2301674589EFCDAB_3210765498FEDCEF;

    repeat (2) @(negedge clk);
    check("rst_read_o", 256'(bus.read_o), 256'(0));
    check("rst_write_o", 256'(bus.write_o), 256'(0));
    check("rst_resp_o", 256'(bus.resp_o), 256'(0));
    check("rst_burst_o", 256'(bus.burst_o), 256'(0));
    check("rst_address_o", 256'(bus.address_o), 256'(0));
    check("rst_line_o", bus.line_o, 256'(0));
    rst = 1'b1;

    do_fill(32'h1234_5678, b1, 16'h0, 0, 1'b0);
    do_write(32'h0000_0040, wline, -1);
    // resp_i pattern 1,0,0,1,0,1,1 (bit k = cycle k)
    do_fill(32'h8000_003F, b2, 16'b110_1001, 7, 1'b0);

    @(negedge clk);
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'h7777_7777_7777_7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_resp_o", 256'(bus.resp_o), 256'(0));
      check("stray_read_o", 256'(bus.read_o), 256'(0));
      check("stray_line_o", bus.line_o, {b2[3], b2[2], b2[1], b2[0]});
    end
    bus.resp_i = 1'b0;

    do_fill(32'h0000_1020, b3, 16'h0, 0, 1'b1);
    do_write(32'h0000_0040, wline, 2);
    do_fill(32'hFFFF_FFE1, b1, 16'b10, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
